// File: rtl/sspi_master.sv
// sspi_master: SPI mode-0 initiator for the monitor's slave command port.
// Issues command frames with a cmd-dependent payload, or one-byte reads.
module sspi_master #(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_start,
    input  logic [7:0]  cmd,
    input  logic [31:0] cmd_arg,
    input  logic [23:0] cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        rd_start,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        sspi_cs,
    output logic        sspi_clk,
    output logic        sspi_mosi,
    input  logic        sspi_miso
);

    localparam int TMAX0 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int TMAX  = (TMAX0 > CS_GAP) ? TMAX0 : CS_GAP;
    localparam int TW    = (TMAX < 2) ? 1 : $clog2(TMAX);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAITB,
        GAP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tmr;
    logic          phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    sr;
    logic [7:0]    rx;
    logic [7:0]    rx_nxt;
    logic [31:0]   pay;
    logic [31:0]   pay_init;
    logic [2:0]    hdr_left;
    logic [2:0]    hdr_init;
    logic [23:0]   str_left;
    logic          rd_frame;

    logic start_any;
    logic div_done;
    logic setup_done;
    logic gap_done;
    logic bit_end;
    logic byte_end;

    assign busy       = (state != IDLE);
    assign wr_ready   = (state == WAITB);
    assign start_any  = cmd_start | rd_start;
    assign div_done   = (tmr == TW'(CLK_DIV - 1));
    assign setup_done = (tmr == TW'(CS_SETUP - 1));
    assign gap_done   = (tmr == TW'(CS_GAP - 1));
    assign bit_end    = phase & div_done;
    assign byte_end   = bit_end & (bit_cnt == 3'd7);

    // MISO is taken in the first cycle of the high phase
    assign rx_nxt = (phase && tmr == '0) ? {rx[6:0], sspi_miso} : rx;

    // Fixed payload, left-aligned so bytes leave from the top
    always_comb begin
        pay_init = {cmd_arg[7:0], 24'h0};
        hdr_init = 3'd1;
        unique case (1'b1)
            (cmd == 8'h02): begin
                pay_init = cmd_arg;
                hdr_init = 3'd4;
            end
            (cmd == 8'h04): begin
                pay_init = {cmd_arg[15:0], 16'h0};
                hdr_init = 3'd2;
            end
            (cmd == 8'h07): begin
                pay_init = {cmd_len, 8'h0};
                hdr_init = 3'd3;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_any) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (setup_done) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (byte_end && hdr_left == 3'd0) begin
                    state_nxt = (str_left != 24'd0) ? WAITB : GAP;
                end
            end
            WAITB: begin
                if (wr_valid) begin
                    state_nxt = SHIFT;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmr       <= '0;
            phase     <= 1'b0;
            bit_cnt   <= 3'd0;
            sr        <= 8'h00;
            rx        <= 8'h00;
            pay       <= 32'h0;
            hdr_left  <= 3'd0;
            str_left  <= 24'd0;
            rd_frame  <= 1'b0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            sspi_cs   <= 1'b1;
            sspi_clk  <= 1'b0;
            sspi_mosi <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            tmr      <= tmr + TW'(1);
            unique case (state)
                IDLE: begin
                    tmr <= '0;
                    if (start_any) begin
                        sspi_cs  <= 1'b0;
                        rd_frame <= ~cmd_start;
                        sr       <= cmd_start ? cmd : 8'h00;
                        pay      <= cmd_start ? pay_init : 32'h0;
                        hdr_left <= cmd_start ? hdr_init : 3'd0;
                        str_left <= (cmd_start && cmd == 8'h07) ? cmd_len : 24'd0;
                    end
                end
                SETUP: begin
                    if (setup_done) begin
                        tmr       <= '0;
                        phase     <= 1'b0;
                        bit_cnt   <= 3'd0;
                        sspi_mosi <= sr[7];
                    end
                end
                SHIFT: begin
                    if (!phase) begin
                        if (div_done) begin
                            tmr      <= '0;
                            phase    <= 1'b1;
                            sspi_clk <= 1'b1;
                        end
                    end else begin
                        rx <= rx_nxt;
                        if (div_done) begin
                            tmr      <= '0;
                            phase    <= 1'b0;
                            sspi_clk <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt   <= bit_cnt + 3'd1;
                                sr        <= {sr[6:0], 1'b0};
                                sspi_mosi <= sr[6];
                            end else if (hdr_left != 3'd0) begin
                                bit_cnt   <= 3'd0;
                                sr        <= pay[31:24];
                                sspi_mosi <= pay[31];
                                pay       <= {pay[23:0], 8'h00};
                                hdr_left  <= hdr_left - 3'd1;
                            end else if (str_left != 24'd0) begin
                                bit_cnt <= 3'd0;
                            end else begin
                                sspi_cs   <= 1'b1;
                                sspi_mosi <= 1'b0;
                                if (rd_frame) begin
                                    rd_data  <= rx_nxt;
                                    rd_valid <= 1'b1;
                                end
                            end
                        end
                    end
                end
                WAITB: begin
                    // SPI clock is stretched low until the stream delivers
                    tmr <= '0;
                    if (wr_valid) begin
                        sr        <= wr_data;
                        sspi_mosi <= wr_data[7];
                        str_left  <= str_left - 24'd1;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        tmr <= '0;
                    end
                end
                default: tmr <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sspi_master.sv
// Testbench for sspi_master: random frames against a byte-level model,
// with a monitor decoding the SPI wires and a scoreboard of expected frames.
module tb_sspi_master;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_GAP   = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_start = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [31:0] cmd_arg = 32'h0;
    logic [23:0] cmd_len = 24'h0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        rd_start = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        sspi_cs;
    logic        sspi_clk;
    logic        sspi_mosi;
    logic        sspi_miso = 1'b0;

    always #5 clk = ~clk;

    sspi_master #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .cmd_start(cmd_start),
        .cmd      (cmd),
        .cmd_arg  (cmd_arg),
        .cmd_len  (cmd_len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_start (rd_start),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .sspi_cs  (sspi_cs),
        .sspi_clk (sspi_clk),
        .sspi_mosi(sspi_mosi),
        .sspi_miso(sspi_miso)
    );

    typedef struct {
        int         nbytes;
        int         cs_len;
        bit         rdv;
        logic [7:0] rdval;
    } frame_t;

    int         vectors = 0;
    int         miscompares = 0;
    frame_t     fr_q[$];
    logic [7:0] exp_b[$];
    logic [7:0] feed_q[$];
    int         stall_q[$];
    logic [7:0] slave_byte = 8'h00;
    bit         mon_en = 1'b0;
    bit         abort = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: frame contents straight from the command rules
    task automatic expect_cmd(input logic [7:0] c, input logic [31:0] a,
                              input logic [23:0] l);
        frame_t      f;
        int          n;
        int          nb;
        logic [31:0] v;
        exp_b.push_back(c);
        nb = 1;
        n = (c == 8'h02) ? 4 : (c == 8'h04) ? 2 : (c == 8'h07) ? 3 : 1;
        v = (c == 8'h07) ? {8'h00, l} : a;
        for (int k = n - 1; k >= 0; k--) begin
            exp_b.push_back(8'((v >> (8 * k)) & 32'hff));
            nb++;
        end
        if (c == 8'h07) begin
            foreach (feed_q[i]) begin
                exp_b.push_back(feed_q[i]);
                nb++;
            end
        end
        f.nbytes = nb;
        f.cs_len = (c == 8'h07 && l != 0) ? -1 : CS_SETUP + nb * 16 * CLK_DIV;
        f.rdv    = 1'b0;
        f.rdval  = 8'h00;
        fr_q.push_back(f);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle timeout", 1, 0);
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [31:0] a,
                            input logic [23:0] l, input bit rd_too);
        wait_idle();
        expect_cmd(c, a, l);
        slave_byte = 8'($urandom);
        cmd       = c;
        cmd_arg   = a;
        cmd_len   = l;
        cmd_start = 1'b1;
        rd_start  = rd_too;
        @(negedge clk);
        cmd_start = 1'b0;
        rd_start  = 1'b0;
        cmd       = 8'($urandom);
        cmd_arg   = $urandom;
        cmd_len   = 24'($urandom);
    endtask

    task automatic send_rd(input logic [7:0] v);
        frame_t f;
        wait_idle();
        exp_b.push_back(8'h00);
        f.nbytes = 1;
        f.cs_len = CS_SETUP + 16 * CLK_DIV;
        f.rdv    = 1'b1;
        f.rdval  = v;
        fr_q.push_back(f);
        slave_byte = v;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
    endtask

    task automatic poke_busy();
        repeat (3) @(negedge clk);
        cmd       = 8'($urandom);
        cmd_start = 1'b1;
        rd_start  = 1'($urandom);
        @(negedge clk);
        cmd_start = 1'b0;
        rd_start  = 1'b0;
    endtask

    // Stream source: optional stall counted in wait cycles, then offer
    bit hs_pend = 1'b0;
    always @(negedge clk) begin
        if (hs_pend) begin
            void'(feed_q.pop_front());
            if (stall_q.size() > 0) void'(stall_q.pop_front());
            hs_pend = 1'b0;
        end
        wr_valid = 1'b0;
        if (feed_q.size() > 0) begin
            if (stall_q.size() > 0 && stall_q[0] > 0) begin
                if (wr_ready) stall_q[0] = stall_q[0] - 1;
            end else begin
                wr_valid = 1'b1;
                wr_data  = feed_q[0];
            end
        end
        hs_pend = wr_valid && wr_ready;
    end

    // Mode-0 slave: bit 7 on select, next bit after each falling SCLK
    logic       s_prev_cs = 1'b1;
    logic       s_prev_clk = 1'b0;
    logic [7:0] s_sh = 8'h00;
    always @(negedge clk) begin
        if (s_prev_cs && !sspi_cs) begin
            s_sh      = slave_byte;
            sspi_miso = s_sh[7];
        end else if (!sspi_cs && s_prev_clk && !sspi_clk) begin
            s_sh      = {s_sh[6:0], 1'b0};
            sspi_miso = s_sh[7];
        end
        s_prev_cs  = sspi_cs;
        s_prev_clk = sspi_clk;
    end

    // Monitor: decode frames off the wires and score them
    logic       m_prev_cs = 1'b1;
    logic       m_prev_clk = 1'b0;
    bit         in_frame = 1'b0;
    bit         gap_on = 1'b0;
    int         cs_cnt = 0;
    int         nrise = 0;
    int         gap_cnt = 0;
    logic [7:0] acc = 8'h00;
    logic [7:0] obs_q[$];
    frame_t     mf;
    logic [7:0] e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_prev_cs && !sspi_cs) begin
                in_frame = 1'b1;
                cs_cnt   = 0;
                nrise    = 0;
                obs_q.delete();
                chk("busy at select", busy, 1);
            end
            if (!sspi_cs) begin
                cs_cnt++;
                if (!m_prev_clk && sspi_clk) begin
                    acc = {acc[6:0], sspi_mosi};
                    nrise++;
                    if (nrise == 1) chk("first sclk rise", cs_cnt, 1 + CS_SETUP + CLK_DIV);
                    if (nrise % 8 == 0) obs_q.push_back(acc);
                end
                if (wr_ready) chk("sclk low while waiting", sspi_clk, 0);
            end else if (wr_ready) begin
                chk("wr_ready outside frame", 1, 0);
            end
            if (!m_prev_cs && sspi_cs && in_frame) begin
                in_frame = 1'b0;
                if (abort) begin
                    abort = 1'b0;
                    if (fr_q.size() > 0) begin
                        mf = fr_q.pop_front();
                        for (int i = 0; i < mf.nbytes; i++) void'(exp_b.pop_front());
                    end
                end else if (fr_q.size() == 0) begin
                    chk("unexpected frame", 1, 0);
                end else begin
                    mf = fr_q.pop_front();
                    chk("sclk rises", nrise, mf.nbytes * 8);
                    for (int i = 0; i < mf.nbytes; i++) begin
                        e = exp_b.pop_front();
                        if (i < obs_q.size()) chk($sformatf("mosi byte %0d", i), obs_q[i], e);
                    end
                    if (mf.cs_len >= 0) chk("cs low cycles", cs_cnt, mf.cs_len);
                    chk("rd_valid at cs rise", rd_valid, mf.rdv);
                    if (mf.rdv) chk("rd_data", rd_data, mf.rdval);
                    gap_on  = 1'b1;
                    gap_cnt = 0;
                end
            end else if (rd_valid) begin
                chk("stray rd_valid", 1, 0);
            end
            if (gap_on) begin
                if (busy) begin
                    gap_cnt++;
                end else begin
                    chk("gap cycles", gap_cnt, CS_GAP);
                    gap_on = 1'b0;
                end
            end
        end
        m_prev_cs  = sspi_cs;
        m_prev_clk = sspi_clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         kind;
        logic [7:0] c;
        logic [23:0] l;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset sspi_cs", sspi_cs, 1);
        chk("reset sspi_clk", sspi_clk, 0);
        chk("reset sspi_mosi", sspi_mosi, 0);
        chk("reset busy", busy, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset wr_ready", wr_ready, 0);
        chk("reset rd_data", rd_data, 0);
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        send_cmd(8'h01, 32'h0, 24'h0, 1'b0);
        send_cmd(8'h02, 32'hA5A5A5A5, 24'h0, 1'b0);
        send_cmd(8'h04, 32'h1234BEEF, 24'h0, 1'b0);
        wait_idle();
        feed_q  = {8'h11, 8'h22, 8'h33};
        stall_q = {0, 10, 0};
        send_cmd(8'h07, 32'h0, 24'd3, 1'b0);
        send_rd(8'h5A);
        send_cmd(8'h33, 32'h000000C3, 24'h0, 1'b1);
        send_cmd(8'h07, 32'h0, 24'd0, 1'b0);

        send_cmd(8'h02, 32'hDEADBEEF, 24'h0, 1'b0);
        repeat (20) @(negedge clk);
        abort  = 1'b1;
        resetn = 1'b0;
        @(negedge clk);
        chk("abort sspi_cs", sspi_cs, 1);
        chk("abort busy", busy, 0);
        chk("abort sspi_clk", sspi_clk, 0);
        chk("abort rd_valid", rd_valid, 0);
        resetn = 1'b1;
        send_rd(8'hC3);

        for (int n = 0; n < 25; n++) begin
            kind = $urandom_range(0, 4);
            if (kind == 0) begin
                send_rd(8'($urandom));
            end else if (kind == 1) begin
                wait_idle();
                l = 24'($urandom_range(0, 3));
                for (int i = 0; i < int'(l); i++) begin
                    feed_q.push_back(8'($urandom));
                    stall_q.push_back($urandom_range(0, 3));
                end
                send_cmd(8'h07, $urandom, l, 1'($urandom));
            end else begin
                c = (kind == 2) ? 8'h02 : (kind == 3) ? 8'h04 : 8'($urandom);
                if (c == 8'h07) c = 8'h08;
                send_cmd(c, $urandom, 24'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 1) == 1) poke_busy();
        end

        wait_idle();
        repeat (CS_GAP + 4) @(negedge clk);
        chk("frames outstanding", fr_q.size(), 0);
        chk("stream bytes outstanding", feed_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sspi_master.md
# sspi_master

Synthesizable SPI initiator for the monitor's slave SPI command channel. It issues command frames (command byte plus a command-dependent payload) and single-byte read frames, and drives the same `sspi_cs`/`sspi_clk`/`sspi_mosi`/`sspi_miso` wires that the `sys` slave port consumes. It is used for on-chip self-test loopback of `sys` and as the host-side engine when one FPGA controls another's monitor core.

## Interface

Parameters:
- `CLK_DIV`, 2: `clk` cycles per SPI clock half-period; legal range ≥1.
- `CS_SETUP`, 2: `clk` cycles from `sspi_cs` falling to the start of the first bit; ≥1.
- `CS_GAP`, 4: `clk` cycles `sspi_cs` stays high after a frame before `busy` drops; ≥1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `resetn`  in  1  reset, synchronous, active-low.
- `cmd_start`  in  1  one-cycle request to send a command frame; honoured only when `busy`=0.
- `cmd`  in  8  command byte; sampled on accepted `cmd_start`.
- `cmd_arg`  in  32  payload argument; sampled on accepted `cmd_start`.
- `cmd_len`  in  24  stream length for cmd 7; sampled on accepted `cmd_start`.
- `wr_data`  in  8  stream byte for cmd 7.
- `wr_valid`  in  1  `wr_data` valid.
- `wr_ready`  out  1  stream byte accepted when `wr_valid`&`wr_ready`.
- `rd_start`  in  1  one-cycle request for a one-byte read frame; honoured only when `busy`=0.
- `rd_data`  out  8  last byte read.
- `rd_valid`  out  1  one-cycle pulse when `rd_data` updates.
- `busy`  out  1  frame or gap in progress.
- `sspi_cs`  out  1  chip select, active-low.
- `sspi_clk`  out  1  SPI clock, idle low.
- `sspi_mosi`  out  1  data to slave.
- `sspi_miso`  in  1  data from slave.

## Operation

- SPI mode 0, MSB first. All SPI outputs are registered.
- Payload selection by latched `cmd`:
  - cmd 2: 4 bytes, `cmd_arg[31:0]`.
  - cmd 4: 2 bytes, `cmd_arg[15:0]`.
  - cmd 7: 3 bytes of `cmd_len[23:0]`, then `cmd_len` bytes from the stream. `cmd_len`=0 sends no stream bytes.
  - Any other cmd: 1 byte, `cmd_arg[7:0]`.
- Read frame: 8 bits with `sspi_mosi`=0; MISO shifted in MSB first.
- FSM states:
  - IDLE→SETUP on an accepted start.
  - SETUP (`CS_SETUP` cycles)→SHIFT.
  - SHIFT→WAITB when the next byte is a stream byte and none is held.
  - WAITB→SHIFT on stream handshake.
  - SHIFT→GAP after the last bit.
  - GAP (`CS_GAP` cycles)→IDLE.
- Bit timing in SHIFT (`2*CLK_DIV` cycles per bit):
  - Low phase, `CLK_DIV` cycles: `sspi_clk`=0 and `sspi_mosi` updated on the first cycle.
  - High phase, `CLK_DIV` cycles: `sspi_clk`=1.
  - `sspi_miso` is captured on the cycle `sspi_clk` rises.
- Stream: `wr_ready`=1 only in WAITB, which is entered at the byte boundary with `sspi_clk` low. The clock is stretched low for as long as `wr_valid`=0. `sspi_cs` stays low throughout.
- `cmd_start` and `rd_start` in the same cycle: `cmd_start` wins and `rd_start` is dropped. Starts while `busy`=1 are ignored and not queued.
- Byte counter is 24 bits wide, plus a 3-bit bit counter; no wrap inside a frame. Maximum stream is 2^24−1 bytes.

## Timing

- Reset values:
  - `sspi_cs`=1, `sspi_clk`=0, `sspi_mosi`=0.
  - `busy`=0, `wr_ready`=0, `rd_valid`=0, `rd_data`=0.
- Reset asserted mid-frame: all outputs take reset values on the next edge. `sspi_cs` rises immediately, with no gap and no `rd_valid`.
- Start accepted in cycle 0:
  - `busy`=1 and `sspi_cs`=0 in cycle 1.
  - First low phase begins in cycle 1+`CS_SETUP`.
- Frame without stalls: `sspi_cs` is low for `CS_SETUP` + `nbits*2*CLK_DIV` cycles, where `nbits` = 8*(1+payload bytes), or 8 for a read frame.
- `sspi_cs` rises on the cycle after the last high phase. The GAP state starts on that cycle.
- Read frame: `rd_data` updates and `rd_valid` pulses on the cycle `sspi_cs` rises.
- `busy` falls after `CS_GAP` cycles with `sspi_cs` high. A new start is accepted in the first cycle `busy`=0.

## Test plan

- Reset check: hold `resetn`=0 for 3 cycles → `sspi_cs`=1, `sspi_clk`=0, `busy`=0, `rd_valid`=0.
- cmd=0x01, `cmd_arg`=0x00 (defaults) → 16 rising edges, MOSI bytes 01 00, `sspi_cs` low for exactly 66 cycles, `busy` falls 4 cycles after `sspi_cs` rises.
- cmd=0x02, `cmd_arg`=0xA5A5A5A5 into a `sys` instance → MOSI bytes 02 A5 A5 A5 A5; `sys.core_config`=0xA5A5A5A5 afterwards.
- cmd=0x04, `cmd_arg`=0x1234BEEF → MOSI bytes 04 BE EF, 24 clocks only.
- cmd=0x07, `cmd_len`=3, stream 11 22 33 with `wr_valid` withheld 10 cycles before byte 22 → bytes 07 00 00 03 11 22 33, `sspi_clk` held low and `sspi_cs` low during the stall, `wr_ready` high only while waiting.
- Read frame with a slave model returning 0x5A → `rd_data`=0x5A with a single `rd_valid` pulse. Then the same-cycle `cmd_start`+`rd_start` case → command frame only, no `rd_valid`. Then `resetn` pulsed mid-frame → `sspi_cs`=1 on the next edge, `busy`=0.
